// File: rtl/fill_pkg.sv
// Shared definitions for the fill auditor: controller states, default
// box geometry and counter widths.
package fill_pkg;

   localparam int unsigned MAX_PILLS       = 20;
   localparam int unsigned BOTTLES_PER_BOX = 40;

   localparam int unsigned PILL_W   = 5;
   localparam int unsigned BOTTLE_W = 6;
   localparam int unsigned TOTAL_W  = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_VERIFY,
      ST_BOX_FULL,
      ST_FAULT
   } state_t;

endpackage

// File: rtl/fill_counter.sv
// Width-parameterised up-counter with synchronous clear, load and increment.
// Priority is reset/clear, then load, then increment.
module fill_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clock) begin
      if (rst || clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (inc) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/fill_auditor.sv
// Pill-filling line auditor: counts pills per bottle against a latched target,
// verifies each bottle, accumulates per-box totals and latches faults.
module fill_auditor #(
   parameter int unsigned BOTTLES_PER_BOX = fill_pkg::BOTTLES_PER_BOX,
   parameter int unsigned MAX_PILLS       = fill_pkg::MAX_PILLS
) (
   input  logic                          clock,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [fill_pkg::PILL_W-1:0]   target,
   input  logic                          pill_pulse,
   input  logic                          bottle_done,
   input  logic                          next_box,
   output logic [fill_pkg::PILL_W-1:0]   pill_cnt,
   output logic [fill_pkg::BOTTLE_W-1:0] bottle_cnt,
   output logic [fill_pkg::TOTAL_W-1:0]  total_cnt,
   output logic                          bottle_ok,
   output logic                          bottle_err,
   output logic                          cfg_err,
   output logic                          box_done,
   output logic                          fault
);

   import fill_pkg::*;

   state_t              state_q, state_d;
   logic [PILL_W-1:0]   target_q;
   logic                ok_q, err_q, ok_d, err_d;
   logic                legal, latch, clr_all;
   logic                pill_inc, pill_clr, pill_ld;
   logic                bot_inc, tot_ld;
   logic                box_will_fill;

   assign legal         = (target != '0) && (32'(target) <= MAX_PILLS);
   assign box_will_fill = (32'(bottle_cnt) + 32'd1) == BOTTLES_PER_BOX;

   always_comb begin
      state_d  = state_q;
      clr_all  = 1'b0;
      latch    = 1'b0;
      pill_inc = 1'b0;
      pill_clr = 1'b0;
      pill_ld  = 1'b0;
      bot_inc  = 1'b0;
      tot_ld   = 1'b0;
      ok_d     = 1'b0;
      err_d    = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         clr_all = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               clr_all = 1'b1;
               if (legal) begin
                  latch   = 1'b1;
                  state_d = ST_COUNT;
               end
            end
            ST_COUNT: begin
               // An overfilling pill wins over a coincident bottle change.
               if (pill_pulse && (pill_cnt == target_q)) begin
                  state_d = ST_FAULT;
               end else begin
                  pill_inc = pill_pulse;
                  if (bottle_done) state_d = ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               if (pill_cnt == target_q) begin
                  ok_d    = 1'b1;
                  bot_inc = 1'b1;
                  tot_ld  = 1'b1;
                  pill_ld  = pill_pulse;
                  pill_clr = !pill_pulse;
                  state_d = box_will_fill ? ST_BOX_FULL : ST_COUNT;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_FAULT;
               end
            end
            ST_BOX_FULL: begin
               if (pill_pulse || bottle_done) begin
                  state_d = ST_FAULT;
               end else if (next_box) begin
                  state_d = ST_IDLE;
                  clr_all = 1'b1;
               end
            end
            ST_FAULT: begin
               if (next_box) begin
                  state_d = ST_IDLE;
                  clr_all = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         target_q <= '0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (latch) target_q <= target;
         ok_q    <= ok_d;
         err_q   <= err_d;
      end
   end

   fill_counter #(.WIDTH(PILL_W)) u_pill (
      .clock    (clock),
      .rst      (rst),
      .clear    (clr_all || pill_clr),
      .inc      (pill_inc),
      .load     (pill_ld),
      .load_val (PILL_W'(1)),
      .count    (pill_cnt)
   );

   fill_counter #(.WIDTH(BOTTLE_W)) u_bottle (
      .clock    (clock),
      .rst      (rst),
      .clear    (clr_all),
      .inc      (bot_inc),
      .load     (1'b0),
      .load_val ('0),
      .count    (bottle_cnt)
   );

   fill_counter #(.WIDTH(TOTAL_W)) u_total (
      .clock    (clock),
      .rst      (rst),
      .clear    (clr_all),
      .inc      (1'b0),
      .load     (tot_ld),
      .load_val (total_cnt + TOTAL_W'(target_q)),
      .count    (total_cnt)
   );

   assign bottle_ok  = ok_q;
   assign bottle_err = err_q;
   assign cfg_err    = (state_q == ST_IDLE) && enable && !legal;
   assign box_done   = (state_q == ST_BOX_FULL);
   assign fault      = (state_q == ST_FAULT);

endmodule

// File: doc/fill_auditor.md
FILL_AUDITOR -- requirements
Module: fill_auditor

Interface
REQ-001 Parameter BOTTLES_PER_BOX, default 40: bottles per box.
REQ-002 Parameter MAX_PILLS, default 20: largest legal per-bottle target.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 enable  input  1  power; low forces IDLE.
REQ-007 target  input  5  pills per bottle; legal range 1..MAX_PILLS.
REQ-008 pill_pulse  input  1  one-cycle strobe, one pill dropped.
REQ-009 bottle_done  input  1  one-cycle strobe, filler changed bottle.
REQ-010 next_box  input  1  one-cycle strobe; restarts after box done or fault.
REQ-011 pill_cnt  output  5  pills counted in current bottle.
REQ-012 bottle_cnt  output  6  bottles verified in current box.
REQ-013 total_cnt  output  10  pills verified in current box.
REQ-014 bottle_ok  output  1  one-cycle strobe, bottle passed.
REQ-015 bottle_err  output  1  one-cycle strobe, bottle failed.
REQ-016 cfg_err  output  1  target illegal while in IDLE.
REQ-017 box_done  output  1  level, state BOX_FULL.
REQ-018 fault  output  1  level, state FAULT.

Function
REQ-019 States: IDLE, COUNT, VERIFY, BOX_FULL, FAULT.
REQ-020 IDLE: enable=1 and target legal -> latch target, clear all counters, go COUNT next cycle; target illegal -> cfg_err=1, stay IDLE.
REQ-021 COUNT: pill_pulse -> pill_cnt+1; pill_pulse with pill_cnt==latched target -> overfill, go FAULT; pill_cnt is not incremented.
REQ-022 COUNT: bottle_done -> go VERIFY; pill_pulse in the same cycle is counted into the current bottle first.
REQ-023 VERIFY lasts exactly one cycle; pill_cnt==target -> bottle_ok=1, bottle_cnt+1, total_cnt+target; otherwise bottle_err=1, go FAULT.
REQ-024 VERIFY pass: pill_cnt cleared; pill_pulse that cycle loads pill_cnt=1 (next bottle); go BOX_FULL if new bottle_cnt==BOTTLES_PER_BOX, else COUNT.
REQ-025 bottle_ok and bottle_err are asserted in the cycle after VERIFY entry is decided, i.e. two cycles after the bottle_done edge sample; never both high.
REQ-026 BOX_FULL: box_done=1; pill_pulse or bottle_done -> go FAULT; next_box -> IDLE.
REQ-027 FAULT: fault=1; all counters frozen; next_box -> IDLE.
REQ-028 bottle_done outside COUNT and BOX_FULL is ignored.
REQ-029 enable=0 in any state -> IDLE next cycle, all counters cleared, strobes low.
REQ-030 total_cnt max = MAX_PILLS*BOTTLES_PER_BOX = 800; no wrap permitted at defaults.
REQ-031 cfg_err is low in every state except IDLE.

Reset
REQ-032 rst=1 -> state IDLE; pill_cnt, bottle_cnt, total_cnt, latched target = 0; bottle_ok, bottle_err, cfg_err, box_done, fault = 0.
REQ-033 rst has priority over enable and all strobes; rst mid-bottle discards the partial count.

Structure
REQ-034 Shared package fill_pkg holds the state enumeration, MAX_PILLS=20, BOTTLES_PER_BOX=40, and counter widths.
REQ-035 One sub-module, fill_counter: width-parameterised counter with synchronous clear, increment and load-value inputs, instantiated for pill_cnt, bottle_cnt and total_cnt.

Verification
REQ-036 target=3, 40 bottles of 3 pills each -> 40 bottle_ok strobes, bottle_cnt=40, total_cnt=120, box_done=1.
REQ-037 target=5, 4 pills then bottle_done -> bottle_err=1 once, fault=1, bottle_cnt unchanged; next_box -> IDLE with all counters 0.
REQ-038 target=2, third pill_pulse before bottle_done -> fault=1, pill_cnt stays 2.
REQ-039 target=0, then target=21 while enable=1 -> cfg_err=1, state stays IDLE; target=20 -> cfg_err=0, state COUNT.
REQ-040 target=4, pill_pulse coincident with bottle_done on the 4th pill -> bottle_ok; pill_pulse during VERIFY -> pill_cnt=1 in the next bottle.
REQ-041 rst asserted mid-bottle with pill_cnt=3, and separately enable dropped in BOX_FULL -> both cases reach IDLE with all outputs 0 the next cycle.
